stage_exe: RTL and testbench

//  Execute stage: consumes decoded controls/operands from regs_idexe, produces ALU result, HI/LO write data and memory controls for regs_exemem.

---
 rtl/mips_cpu_pkg.sv | 45 ++++
 rtl/stage_exe_if.sv | 48 ++++
 rtl/mips_divider.sv | 96 +++++++++
 rtl/stage_exe.sv | 128 ++++++++++++
 tb/tb_stage_exe.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared encodings for the execute stage: alutype bit positions, per-type op codes,
// divider state and the single restoring-division step used by the divider.
package mips_cpu_pkg;

  localparam int DIV_CYCLES = 32;

  localparam int ALU_MULDIV = 0;
  localparam int ALU_ARITH  = 1;
  localparam int ALU_LOGIC  = 2;
  localparam int ALU_MOVE   = 3;
  localparam int ALU_SHIFT  = 4;

  localparam logic [2:0] OP_ADD  = 3'b000, OP_SUB  = 3'b001, OP_SLT  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b000, OP_OR   = 3'b001, OP_XOR  = 3'b010,
                         OP_NOR  = 3'b011, OP_LUI  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b000, OP_SRL  = 3'b001, OP_SRA  = 3'b010;
  localparam logic [2:0] OP_MFHI = 3'b000, OP_MFLO = 3'b001, OP_MTHI = 3'b010,
                         OP_MTLO = 3'b011;
  localparam logic [2:0] OP_MULT = 3'b000, OP_DIV  = 3'b001;

  typedef logic [3:0] memop_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_onehot5(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  // One radix-2 restoring step: shift the next dividend bit into the partial
  // remainder, subtract when it fits. Returns {remainder, quotient}.
  function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                           input logic [31:0] dsr);
    logic [32:0] t;
    logic [33:0] diff;
    t    = {rem, quo[31]};
    diff = {1'b0, t} - {2'b00, dsr};
    if (!diff[33]) return {diff[31:0], quo[30:0], 1'b1};
    return {t[31:0], quo[30:0], 1'b0};
  endfunction

endpackage

// File: rtl/stage_exe_if.sv
// Bundle between regs_idexe / HI-LO forwarding and the execute stage outputs to regs_exemem.
interface stage_exe_if;
  import mips_cpu_pkg::*;

  // Handshake: there is no valid/ready pair; exe_o_stallreq=1 means upstream must hold every
  // exe_i_* input stable and regs_exemem takes a bubble; the cycle it is 0 the outputs are final.
  logic [4:0]  exe_i_alutype;
  logic [4:0]  exe_i_aluop;
  logic [31:0] exe_i_src1;
  logic [31:0] exe_i_src2;
  logic [4:0]  exe_i_rfwa;
  logic        exe_i_rfwe;
  logic        exe_i_dm2rf;
  logic        exe_i_hilowe;
  logic [31:0] exe_i_dmdin;
  memop_t      exe_i_memop;
  logic        exe_i_flush;
  logic [31:0] hilo_i_hi;
  logic [31:0] hilo_i_lo;

  logic [4:0]  exe_o_rfwa;
  logic        exe_o_rfwe;
  logic        exe_o_dm2rf;
  logic        exe_o_hilowe;
  logic [31:0] exe_o_dmdin;
  memop_t      exe_o_memop;
  logic [31:0] exe_o_result;
  logic [31:0] exe_o_hi;
  logic [31:0] exe_o_lo;
  logic        exe_o_ov;
  logic        exe_o_stallreq;
  div_state_e  dbg_div_state;

  modport master (
    output exe_i_alutype, exe_i_aluop, exe_i_src1, exe_i_src2, exe_i_rfwa, exe_i_rfwe,
           exe_i_dm2rf, exe_i_hilowe, exe_i_dmdin, exe_i_memop, exe_i_flush, hilo_i_hi, hilo_i_lo,
    input  exe_o_rfwa, exe_o_rfwe, exe_o_dm2rf, exe_o_hilowe, exe_o_dmdin, exe_o_memop,
           exe_o_result, exe_o_hi, exe_o_lo, exe_o_ov, exe_o_stallreq, dbg_div_state
  );

  modport slave (
    input  exe_i_alutype, exe_i_aluop, exe_i_src1, exe_i_src2, exe_i_rfwa, exe_i_rfwe,
           exe_i_dm2rf, exe_i_hilowe, exe_i_dmdin, exe_i_memop, exe_i_flush, hilo_i_hi, hilo_i_lo,
    output exe_o_rfwa, exe_o_rfwe, exe_o_dm2rf, exe_o_hilowe, exe_o_dmdin, exe_o_memop,
           exe_o_result, exe_o_hi, exe_o_lo, exe_o_ov, exe_o_stallreq, dbg_div_state
  );

endinterface

// File: rtl/mips_divider.sv
// Iterative 32-bit radix-2 restoring divider (signed/unsigned) with abort.
// busy covers the latch cycle plus BUSY; done is a one-cycle pulse in DONE.
module mips_divider
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output div_state_e  state
);

  div_state_e  state_nxt;
  logic [4:0]  cnt;
  logic [31:0] rem_q, quo_q, dsr_q, dvd_q;
  logic        q_neg_q, r_neg_q, zero_q;
  logic [31:0] abs_dvd, abs_dsr;
  logic [63:0] first_step, next_step;
  logic        latch;

  assign abs_dvd    = (sign && dividend[31]) ? (32'd0 - dividend) : dividend;
  assign abs_dsr    = (sign && divisor[31])  ? (32'd0 - divisor)  : divisor;
  assign latch      = (state == DIV_IDLE) && start && !abort;
  assign first_step = div_step(32'd0, abs_dvd, abs_dsr);
  assign next_step  = div_step(rem_q, quo_q, dsr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      DIV_IDLE: if (start) begin
        state_nxt = DIV_BUSY;
        busy      = 1'b1;
      end
      DIV_BUSY: begin
        busy = 1'b1;
        if (cnt == 5'(DIV_CYCLES - 1)) state_nxt = DIV_DONE;
      end
      DIV_DONE: begin
        done      = 1'b1;
        state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
    if (abort) begin
      state_nxt = DIV_IDLE;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

  // The latch cycle already performs step 1, so cnt counts completed steps and
  // the 32nd step lands on the BUSY->DONE edge: 32 stalled cycles in total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      dvd_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
    end else if (latch) begin
      {rem_q, quo_q} <= first_step;
      dsr_q   <= abs_dsr;
      dvd_q   <= dividend;
      q_neg_q <= sign && (dividend[31] ^ divisor[31]);
      r_neg_q <= sign && dividend[31];
      zero_q  <= (divisor == 32'd0);
      cnt     <= 5'd1;
    end else if (state == DIV_BUSY) begin
      {rem_q, quo_q} <= next_step;
      cnt <= cnt + 5'd1;
    end
  end

  assign quotient  = zero_q ? 32'hFFFF_FFFF : (q_neg_q ? (32'd0 - quo_q) : quo_q);
  assign remainder = zero_q ? dvd_q         : (r_neg_q ? (32'd0 - rem_q) : rem_q);

endmodule

// File: rtl/stage_exe.sv
// Execute stage: single-cycle ALU/shift/move/multiply plus the iterative divider,
// with write-enable squashing for overflow, flush and malformed alutype.
module stage_exe
  import mips_cpu_pkg::*;
(
  input  logic       cpu_clk_50M,
  input  logic       cpu_rst_n,
  stage_exe_if.slave exe
);

  logic [31:0] src1, src2, sum, diff;
  logic [4:0]  alutype;
  logic [2:0]  op;
  logic        sgn, err, type_ok, slt, ov_add, ov_sub;
  logic [63:0] prod_s, prod_u;
  logic        is_div, div_start, div_busy, div_done;
  logic [31:0] div_quo, div_rem;
  logic [31:0] result_c, hi_c, lo_c;
  logic        ov_c, rfwe_c, hilowe_c;

  assign src1    = exe.exe_i_src1;
  assign src2    = exe.exe_i_src2;
  assign alutype = exe.exe_i_alutype;
  assign op      = exe.exe_i_aluop[4:2];
  assign sgn     = exe.exe_i_aluop[1];
  assign err     = exe.exe_i_aluop[0];
  assign type_ok = is_onehot5(alutype);

  assign sum    = src1 + src2;
  assign diff   = src1 - src2;
  assign ov_add = (src1[31] == src2[31]) && (sum[31] != src1[31]);
  assign ov_sub = (src1[31] != src2[31]) && (diff[31] != src1[31]);
  assign slt    = sgn ? ($signed(src1) < $signed(src2)) : (src1 < src2);
  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
  assign prod_u = {32'd0, src1} * {32'd0, src2};

  assign is_div    = type_ok && alutype[ALU_MULDIV] && (op == OP_DIV);
  assign div_start = is_div && !exe.exe_i_flush;

  mips_divider u_div (
    .clk       (cpu_clk_50M),
    .rst_n     (cpu_rst_n),
    .start     (div_start),
    .sign      (sgn),
    .dividend  (src1),
    .divisor   (src2),
    .abort     (exe.exe_i_flush),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .state     (exe.dbg_div_state)
  );

  always_comb begin
    result_c = '0;
    hi_c     = '0;
    lo_c     = '0;
    ov_c     = 1'b0;
    rfwe_c   = exe.exe_i_rfwe;
    hilowe_c = exe.exe_i_hilowe;
    if (!type_ok) begin
      rfwe_c   = 1'b0;
      hilowe_c = 1'b0;
    end else if (alutype[ALU_ARITH]) begin
      case (op)
        OP_ADD: begin result_c = sum;  ov_c = err & ov_add; end
        OP_SUB: begin result_c = diff; ov_c = err & ov_sub; end
        OP_SLT: result_c = {31'd0, slt};
        default: ;
      endcase
    end else if (alutype[ALU_LOGIC]) begin
      case (op)
        OP_AND: result_c = src1 & src2;
        OP_OR:  result_c = src1 | src2;
        OP_XOR: result_c = src1 ^ src2;
        OP_NOR: result_c = ~(src1 | src2);
        OP_LUI: result_c = src2;
        default: ;
      endcase
    end else if (alutype[ALU_SHIFT]) begin
      case (op)
        OP_SLL: result_c = src2 << src1[4:0];
        OP_SRL: result_c = src2 >> src1[4:0];
        OP_SRA: result_c = $signed(src2) >>> src1[4:0];
        default: ;
      endcase
    end else if (alutype[ALU_MOVE]) begin
      case (op)
        OP_MFHI: result_c = exe.hilo_i_hi;
        OP_MFLO: result_c = exe.hilo_i_lo;
        OP_MTHI: begin hi_c = src1;          lo_c = exe.hilo_i_lo; end
        OP_MTLO: begin hi_c = exe.hilo_i_hi; lo_c = src1;          end
        default: ;
      endcase
    end else begin
      case (op)
        OP_MULT: {hi_c, lo_c} = sgn ? prod_s : prod_u;
        OP_DIV: begin
          hi_c     = div_rem;
          lo_c     = div_quo;
          hilowe_c = exe.exe_i_hilowe & div_done;
        end
        default: ;
      endcase
    end
    if (ov_c) rfwe_c = 1'b0;
    if (exe.exe_i_flush) begin
      rfwe_c   = 1'b0;
      hilowe_c = 1'b0;
    end
  end

  // Outputs are held at zero for as long as reset is asserted.
  assign exe.exe_o_result   = cpu_rst_n ? result_c : '0;
  assign exe.exe_o_hi       = cpu_rst_n ? hi_c : '0;
  assign exe.exe_o_lo       = cpu_rst_n ? lo_c : '0;
  assign exe.exe_o_ov       = cpu_rst_n & ov_c;
  assign exe.exe_o_rfwe     = cpu_rst_n & rfwe_c;
  assign exe.exe_o_hilowe   = cpu_rst_n & hilowe_c;
  assign exe.exe_o_stallreq = cpu_rst_n & div_busy;
  assign exe.exe_o_rfwa     = cpu_rst_n ? exe.exe_i_rfwa : '0;
  assign exe.exe_o_dm2rf    = cpu_rst_n & exe.exe_i_dm2rf;
  assign exe.exe_o_dmdin    = cpu_rst_n ? exe.exe_i_dmdin : '0;
  assign exe.exe_o_memop    = cpu_rst_n ? exe.exe_i_memop : '0;

endmodule

// File: tb/tb_stage_exe.sv
// Bench for stage_exe: table of single-cycle ops, random signed adds, flush,
// division sequences (stall length, results) and reset in the middle of a division.
module tb_stage_exe;
  import mips_cpu_pkg::*;

  localparam int W    = 100;
  localparam int PT_W = 42;
  localparam logic [4:0] MD = 5'b00001, AR = 5'b00010, LG = 5'b00100,
                         MV = 5'b01000, SH = 5'b10000;

  typedef struct packed {
    logic [4:0]   at;
    logic [4:0]   op;
    logic [31:0]  a;
    logic [31:0]  b;
    logic         we;
    logic         hwe;
    logic [W-1:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [W-1:0]    exp_q[$];
  logic [PT_W-1:0] pt_exp;
  vec_t            vecs[24];

  stage_exe_if bus ();

  stage_exe dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .exe         (bus)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] aop(input logic [2:0] o, input logic s, input logic e);
    return {o, s, e};
  endfunction

  function automatic logic [W-1:0] ex(input logic [31:0] r, input logic [31:0] h,
                                      input logic [31:0] l, input logic ov, input logic we,
                                      input logic hwe, input logic st);
    return {r, h, l, ov, we, hwe, st};
  endfunction

  function automatic logic [W-1:0] obs();
    return {bus.exe_o_result, bus.exe_o_hi, bus.exe_o_lo, bus.exe_o_ov,
            bus.exe_o_rfwe, bus.exe_o_hilowe, bus.exe_o_stallreq};
  endfunction

  function automatic logic [W-1:0] pt_obs();
    return {{(W-PT_W){1'b0}}, bus.exe_o_rfwa, bus.exe_o_dm2rf, bus.exe_o_dmdin, bus.exe_o_memop};
  endfunction

  function automatic logic [W-1:0] zx32(input logic [31:0] v);
    return {{(W-32){1'b0}}, v};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // scoreboard: pop the oldest expectation and compare against the DUT now
  task automatic sb_check(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got empty queue want queued expectation", name);
    end else begin
      e = exp_q.pop_front();
      check(name, obs(), e);
    end
    check({name, "_pass"}, pt_obs(), {{(W-PT_W){1'b0}}, pt_exp});
  endtask

  // driver: new inputs 1 time unit after the rising edge
  task automatic apply(input logic [4:0] at, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic we, input logic hwe, input logic fl);
    @(posedge clk);
    #1;
    bus.exe_i_alutype = at;
    bus.exe_i_aluop   = op;
    bus.exe_i_src1    = a;
    bus.exe_i_src2    = b;
    bus.exe_i_rfwe    = we;
    bus.exe_i_hilowe  = hwe;
    bus.exe_i_flush   = fl;
    bus.hilo_i_hi     = 32'h1111_1111;
    bus.hilo_i_lo     = 32'h2222_2222;
    bus.exe_i_rfwa    = 5'($urandom_range(0, 31));
    bus.exe_i_dm2rf   = 1'($urandom_range(0, 1));
    bus.exe_i_dmdin   = $urandom;
    bus.exe_i_memop   = 4'($urandom_range(0, 15));
    pt_exp = {bus.exe_i_rfwa, bus.exe_i_dm2rf, bus.exe_i_dmdin, bus.exe_i_memop};
  endtask

  task automatic run_div(input string name, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
    int n;
    apply(MD, aop(OP_DIV, sg, 1'b0), a, b, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(ex(32'h0, r, q, 1'b0, 1'b0, 1'b1, 1'b0));
    n = 0;
    @(negedge clk);
    check({name, "_first"}, zx32({30'd0, bus.exe_o_hilowe, bus.exe_o_stallreq}), zx32(32'd1));
    while (bus.exe_o_stallreq && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_stalls"}, zx32(n), zx32(32'd32));
    sb_check(name);
  endtask

  initial begin
    logic [31:0] a, b;
    logic signed [32:0] s;
    logic ov;
    total = 0;
    bad   = 0;

    // reset state
    rst_n = 1'b0;
    bus.exe_i_alutype = AR;  bus.exe_i_aluop = aop(OP_ADD, 1'b1, 1'b0);
    bus.exe_i_src1 = 32'd1;  bus.exe_i_src2 = 32'd2;
    bus.exe_i_rfwa = 5'd7;   bus.exe_i_rfwe = 1'b1;  bus.exe_i_dm2rf = 1'b1;
    bus.exe_i_hilowe = 1'b1; bus.exe_i_dmdin = 32'hDEAD_BEEF; bus.exe_i_memop = 4'h5;
    bus.exe_i_flush = 1'b0;  bus.hilo_i_hi = 32'h1; bus.hilo_i_lo = 32'h2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", obs(), '0);
    check("reset_pass", pt_obs(), '0);
    check("reset_state", {{(W-2){1'b0}}, bus.dbg_div_state}, {{(W-2){1'b0}}, DIV_IDLE});
    rst_n = 1'b1;

    vecs[0]  = '{AR, aop(OP_ADD, 1'b1, 1'b1), 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0, ex(32'h80000000, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[1]  = '{AR, aop(OP_ADD, 1'b0, 1'b0), 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0, ex(32'h80000000, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[2]  = '{AR, aop(OP_SUB, 1'b1, 1'b1), 32'h80000000, 32'h1, 1'b1, 1'b0, ex(32'h7FFFFFFF, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[3]  = '{AR, aop(OP_SUB, 1'b0, 1'b0), 32'h5, 32'h7, 1'b1, 1'b0, ex(32'hFFFFFFFE, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[4]  = '{AR, aop(OP_SLT, 1'b1, 1'b0), 32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, ex(32'h1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[5]  = '{AR, aop(OP_SLT, 1'b0, 1'b0), 32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, ex(32'h0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[6]  = '{LG, aop(OP_AND, 1'b0, 1'b0), 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 1'b0, ex(32'h00F000F0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[7]  = '{LG, aop(OP_OR,  1'b0, 1'b0), 32'h12340000, 32'h00005678, 1'b1, 1'b0, ex(32'h12345678, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[8]  = '{LG, aop(OP_XOR, 1'b0, 1'b0), 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 1'b0, ex(32'hF0F00F0F, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[9]  = '{LG, aop(OP_NOR, 1'b0, 1'b0), 32'h0000FFFF, 32'h00FF0000, 1'b1, 1'b0, ex(32'hFF000000, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[10] = '{LG, aop(OP_LUI, 1'b0, 1'b0), 32'h00000123, 32'hABCD0000, 1'b1, 1'b0, ex(32'hABCD0000, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[11] = '{SH, aop(OP_SLL, 1'b0, 1'b0), 32'h8, 32'hFF, 1'b1, 1'b0, ex(32'h0000FF00, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[12] = '{SH, aop(OP_SRL, 1'b0, 1'b0), 32'h4, 32'h80000000, 1'b1, 1'b0, ex(32'h08000000, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[13] = '{SH, aop(OP_SRA, 1'b0, 1'b0), 32'h4, 32'h80000000, 1'b1, 1'b0, ex(32'hF8000000, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[14] = '{MV, aop(OP_MFHI, 1'b0, 1'b0), 32'h0, 32'h0, 1'b1, 1'b0, ex(32'h11111111, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[15] = '{MV, aop(OP_MFLO, 1'b0, 1'b0), 32'h0, 32'h0, 1'b1, 1'b0, ex(32'h22222222, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[16] = '{MV, aop(OP_MTHI, 1'b0, 1'b0), 32'hCAFEBABE, 32'h0, 1'b0, 1'b1, ex(32'h0, 32'hCAFEBABE, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0)};
    vecs[17] = '{MV, aop(OP_MTLO, 1'b0, 1'b0), 32'hCAFEBABE, 32'h0, 1'b0, 1'b1, ex(32'h0, 32'h11111111, 32'hCAFEBABE, 1'b0, 1'b0, 1'b1, 1'b0)};
    vecs[18] = '{MD, aop(OP_MULT, 1'b1, 1'b0), 32'hFFFFFFFD, 32'h5, 1'b0, 1'b1, ex(32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b1, 1'b0)};
    vecs[19] = '{MD, aop(OP_MULT, 1'b0, 1'b0), 32'hFFFFFFFF, 32'h2, 1'b0, 1'b1, ex(32'h0, 32'h1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0)};
    vecs[20] = '{5'b00110, aop(OP_ADD, 1'b0, 1'b0), 32'h1, 32'h2, 1'b1, 1'b1, ex(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[21] = '{5'b00000, aop(OP_ADD, 1'b0, 1'b0), 32'h1, 32'h2, 1'b1, 1'b1, ex(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[22] = '{AR, aop(OP_ADD, 1'b1, 1'b1), 32'h5, 32'h7, 1'b1, 1'b0, ex(32'hC, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[23] = '{MD, aop(OP_MULT, 1'b1, 1'b0), 32'h80000000, 32'h80000000, 1'b0, 1'b1, ex(32'h0, 32'h40000000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0)};

    for (int i = 0; i < 24; i++) begin
      apply(vecs[i].at, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].we, vecs[i].hwe, 1'b0);
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      sb_check($sformatf("vec%0d", i));
    end

    // random signed ADD with overflow trap
    for (int i = 0; i < 8; i++) begin
      a  = $urandom;
      b  = $urandom;
      s  = $signed({a[31], a}) + $signed({b[31], b});
      ov = s[32] ^ s[31];
      apply(AR, aop(OP_ADD, 1'b1, 1'b1), a, b, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(ex(s[31:0], 0, 0, ov, !ov, 1'b0, 1'b0));
      @(negedge clk);
      sb_check($sformatf("rand_add%0d", i));
    end

    // flush squashes write enables of single-cycle ops
    apply(AR, aop(OP_ADD, 1'b0, 1'b0), 32'h3, 32'h4, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(ex(32'h7, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    sb_check("flush_add");
    apply(MD, aop(OP_MULT, 1'b1, 1'b0), 32'hFFFFFFFD, 32'h5, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(ex(32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    sb_check("flush_mult");

    // divisions, back to back
    run_div("div_m7_2",    1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("divu_7_0",    1'b0, 32'h7, 32'h0, 32'hFFFFFFFF, 32'h7);
    run_div("divu_100_7",  1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("div_7_m2",    1'b1, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1);
    run_div("div_m8_0",    1'b1, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF8);
    run_div("divu_max_1",  1'b0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0);
    run_div("div_min_m1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom_range(1, 1000);
      run_div($sformatf("divu_rand%0d", i), 1'b0, a, b, a / b, a % b);
    end

    // flush in the 10th BUSY cycle
    apply(MD, aop(OP_DIV, 1'b0, 1'b0), 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("flush_busy_state", {{(W-2){1'b0}}, bus.dbg_div_state}, {{(W-2){1'b0}}, DIV_BUSY});
    bus.exe_i_flush = 1'b1;
    #1;
    check("flush_drop", zx32({29'd0, bus.exe_o_stallreq, bus.exe_o_hilowe, bus.exe_o_rfwe}), zx32(32'd0));
    @(posedge clk);
    #1;
    bus.exe_i_flush   = 1'b0;
    bus.exe_i_alutype = 5'b00000;
    @(negedge clk);
    check("flush_idle", {{(W-2){1'b0}}, bus.dbg_div_state, bus.exe_o_stallreq}, '0);
    run_div("div_after_flush", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    // reset in the 5th BUSY cycle
    apply(MD, aop(OP_DIV, 1'b1, 1'b0), 32'hFFFFFFF9, 32'h2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", obs(), '0);
    check("rst_mid_pass", pt_obs(), '0);
    check("rst_mid_state", {{(W-2){1'b0}}, bus.dbg_div_state}, {{(W-2){1'b0}}, DIV_IDLE});
    bus.exe_i_alutype = 5'b00000;
    @(negedge clk);
    rst_n = 1'b1;
    run_div("div_after_rst", 1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
